// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: bus widths, the arbiter state encoding and the
// register-ROM marker words understood by the setup sequencer.
package sccb_pkg;

    localparam int SCCB_ADDR_W = 8;
    localparam int SCCB_DATA_W = 8;
    localparam int ARB_STATE_W = 3;

    // ROM entries with these values are control words, not register writes.
    localparam logic [15:0] ROM_END_MARKER   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY_MARKER = 16'hFFF0;

    typedef enum logic [ARB_STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_BUSY  = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_FINISH     = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sccb_rr_pick.sv
// Combinational round-robin picker: first set request bit found searching
// upward from last_grant+1, wrapping modulo NUM_REQ.
module sccb_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int GRANT_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [GRANT_W-1:0] winner,
    output logic               any_valid
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (req[idx]) begin
                winner    = GRANT_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB register-write master among NUM_REQ
// requesters, with a watchdog that aborts stalled ready handshakes.
module sccb_arbiter
    import sccb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [SCCB_ADDR_W*NUM_REQ-1:0] req_sub_address,
    input  logic [SCCB_DATA_W*NUM_REQ-1:0] req_set_data,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             req_done,
    output logic                           xfer_err,
    output logic                           timeout_flag,
    output logic                           busy,
    input  logic                           SCCB_ready_signal,
    output logic                           sccb_start_sign,
    output logic [SCCB_ADDR_W-1:0]         sccb_sub_address,
    output logic [SCCB_DATA_W-1:0]         sccb_set_data,
    output logic [ARB_STATE_W-1:0]         state_dbg
);

    localparam int GW = $clog2(NUM_REQ);

    // Handshakes: a requester holds req_valid and its data until a one-cycle
    // req_ack; the master accepts a job only while SCCB_ready_signal=1, takes
    // it on the start pulse, drops ready while working and raises it when done.
    arb_state_t               state, state_next;
    logic [GW-1:0]            grant, grant_next;
    logic [GW-1:0]            last_grant, last_next;
    logic [31:0]              timer, timer_next;
    logic                     err, err_next;
    logic                     flag_next, start_next, xerr_next, busy_next;
    logic [NUM_REQ-1:0]       ack_next, done_next;
    logic [SCCB_ADDR_W-1:0]   addr_next;
    logic [SCCB_DATA_W-1:0]   data_next;
    logic [GW-1:0]            winner;
    logic                     any_valid;

    sccb_rr_pick #(.NUM_REQ(NUM_REQ), .GRANT_W(GW)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    assign state_dbg = state;

    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last_grant;
        timer_next = timer;
        err_next   = err;
        flag_next  = timeout_flag;
        addr_next  = sccb_sub_address;
        data_next  = sccb_set_data;
        start_next = 1'b0;
        xerr_next  = 1'b0;
        ack_next   = '0;
        done_next  = '0;
        case (state)
            ST_IDLE: begin
                if (any_valid && SCCB_ready_signal) begin
                    grant_next = winner;
                    last_next  = winner;
                    addr_next  = req_sub_address[SCCB_ADDR_W*winner +: SCCB_ADDR_W];
                    data_next  = req_set_data[SCCB_DATA_W*winner +: SCCB_DATA_W];
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_next = 1'b1;
                ack_next   = NUM_REQ'(1) << grant;
                timer_next = 32'(TIMEOUT_CYCLES);
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_WAIT_READY: begin
                if (timer != '0) timer_next = timer - 32'd1;
                if ((state == ST_WAIT_BUSY) ? !SCCB_ready_signal : SCCB_ready_signal) begin
                    state_next = (state == ST_WAIT_BUSY) ? ST_WAIT_READY : ST_FINISH;
                end else if (timer == '0) begin
                    err_next   = 1'b1;
                    flag_next  = 1'b1;
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_next  = NUM_REQ'(1) << grant;
                xerr_next  = err;
                err_next   = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            grant            <= '0;
            last_grant       <= GW'(NUM_REQ - 1);
            timer            <= '0;
            err              <= 1'b0;
            timeout_flag     <= 1'b0;
            sccb_sub_address <= '0;
            sccb_set_data    <= '0;
            sccb_start_sign  <= 1'b0;
            req_ack          <= '0;
            req_done         <= '0;
            xfer_err         <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_next;
            grant            <= grant_next;
            last_grant       <= last_next;
            timer            <= timer_next;
            err              <= err_next;
            timeout_flag     <= flag_next;
            sccb_sub_address <= addr_next;
            sccb_set_data    <= data_next;
            sccb_start_sign  <= start_next;
            req_ack          <= ack_next;
            req_done         <= done_next;
            xfer_err         <= xerr_next;
            busy             <= busy_next;
        end
    end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Self-checking bench for sccb_arbiter: behavioural SCCB master model plus a
// round-robin reference model and randomized multi-requester traffic.
module tb_sccb_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TMO     = 100;
    localparam int W       = $clog2(NUM_REQ);
    localparam int M_MANUAL = 0, M_NORMAL = 1, M_NEVER = 2, M_STUCK = 3;

    logic                   clk, reset, ready;
    logic [NUM_REQ-1:0]     req_valid, req_ack, req_done;
    logic [8*NUM_REQ-1:0]   req_sub_address, req_set_data;
    logic                   xfer_err, timeout_flag, busy, sccb_start_sign;
    logic [7:0]             sccb_sub_address, sccb_set_data;
    logic [2:0]             state_dbg;

    int tests_run = 0, tests_failed = 0;
    int start_cnt = 0, done_cnt = 0, overlap_cnt = 0, ack_bad_cnt = 0;
    int m_mode = M_NORMAL, m_drop = 2, m_low = 50;
    int m_last = NUM_REQ - 1;
    logic [W-1:0] exp_q[$];

    sccb_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_sub_address(req_sub_address), .req_set_data(req_set_data),
        .req_ack(req_ack), .req_done(req_done), .xfer_err(xfer_err),
        .timeout_flag(timeout_flag), .busy(busy), .SCCB_ready_signal(ready),
        .sccb_start_sign(sccb_start_sign), .sccb_sub_address(sccb_sub_address),
        .sccb_set_data(sccb_set_data), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_last = NUM_REQ - 1;
    endtask

    // ---------------- SCCB master model ----------------
    initial begin
        ready = 1'b1;
        forever begin
            @(negedge clk);
            if (m_mode != M_MANUAL && sccb_start_sign && !reset) begin
                if (m_mode == M_NORMAL || m_mode == M_STUCK) begin
                    repeat (m_drop) @(negedge clk);
                    ready = 1'b0;
                    if (m_mode == M_NORMAL) begin
                        repeat (m_low) @(negedge clk);
                        ready = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- protocol monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            done_cnt = start_cnt;
        end else begin
            if (sccb_start_sign) begin
                if (start_cnt != done_cnt) overlap_cnt++;
                start_cnt++;
            end
            if (req_done != '0) done_cnt++;
            if ((req_ack != '0) != sccb_start_sign) ack_bad_cnt++;
        end
    end

    // ---------------- reference model ----------------
    function automatic int rr_model(input logic [NUM_REQ-1:0] pend, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (pend[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] d);
        req_valid[i] = 1'b1;
        req_sub_address[8*i +: 8] = a;
        req_set_data[8*i +: 8] = d;
    endtask

    task automatic wait_start(input int budget, output bit seen, output int n);
        seen = 0;
        n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (sccb_start_sign) seen = 1;
        end
    endtask

    task automatic wait_done(input int budget, output bit seen, output int n);
        seen = 0;
        n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (req_done != '0) seen = 1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        req_sub_address = '0;
        req_set_data = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req_ack, req_done, xfer_err, timeout_flag, busy, sccb_start_sign} !== '0)
            begin tests_failed++; $display("FAIL reset_ctrl got ack=%b done=%b err=%b flag=%b busy=%b start=%b exp all 0",
                req_ack, req_done, xfer_err, timeout_flag, busy, sccb_start_sign); end
        tests_run++;
        if ({sccb_sub_address, sccb_set_data} !== 16'h0)
            begin tests_failed++; $display("FAIL reset_bus got addr=%h data=%h exp 00/00", sccb_sub_address, sccb_set_data); end
        reset = 1'b0;
        m_last = NUM_REQ - 1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle busy=%b exp 0", busy); end
    endtask

    task automatic test_single();
        bit seen; int n;
        m_mode = M_NORMAL; m_drop = 2; m_low = 50;
        set_req(0, 8'h12, 8'h80);
        wait_start(20, seen, n);
        tests_run++;
        if (!seen || n != 2) begin tests_failed++; $display("FAIL single_start_lat seen=%0d n=%0d exp 2", seen, n); end
        tests_run++;
        if (req_ack !== 2'b01) begin tests_failed++; $display("FAIL single_ack got=%b exp=01", req_ack); end
        tests_run++;
        if (sccb_sub_address !== 8'h12 || sccb_set_data !== 8'h80)
            begin tests_failed++; $display("FAIL single_bus got=%h/%h exp=12/80", sccb_sub_address, sccb_set_data); end
        req_valid[0] = 1'b0;
        m_last = 0;
        wait_done(200, seen, n);
        tests_run++;
        if (!seen || n != m_drop + m_low + 2)
            begin tests_failed++; $display("FAIL single_done_lat seen=%0d n=%0d exp %0d", seen, n, m_drop + m_low + 2); end
        tests_run++;
        if (req_done !== 2'b01 || xfer_err !== 1'b0)
            begin tests_failed++; $display("FAIL single_done got done=%b err=%b exp 01/0", req_done, xfer_err); end
        @(negedge clk);
        tests_run++;
        if (sccb_sub_address !== 8'h12 || sccb_set_data !== 8'h80 || req_done !== 2'b00)
            begin tests_failed++; $display("FAIL single_hold got=%h/%h done=%b exp=12/80/00", sccb_sub_address, sccb_set_data, req_done); end
    endtask

    task automatic test_contention();
        bit seen; int n, got, e, s0;
        logic [7:0] ea, ed;
        do_reset();
        m_mode = M_NORMAL; m_drop = 1; m_low = 5;
        s0 = start_cnt;
        set_req(0, 8'h11, 8'h01);
        set_req(1, 8'h3A, 8'h04);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(W'(rr_model(2'b11, m_last)));
            wait_start(30, seen, n);
            got = oh_idx(req_ack);
            e = int'(exp_q.pop_front());
            m_last = e;
            tests_run++;
            if (!seen || got != e) begin tests_failed++; $display("FAIL contention_grant%0d seen=%0d got=%0d exp=%0d", k, seen, got, e); end
            ea = (e == 0) ? 8'h11 : 8'h3A;
            ed = (e == 0) ? 8'h01 : 8'h04;
            tests_run++;
            if (sccb_sub_address !== ea || sccb_set_data !== ed)
                begin tests_failed++; $display("FAIL contention_bus%0d got=%h/%h exp=%h/%h", k, sccb_sub_address, sccb_set_data, ea, ed); end
            wait_done(100, seen, n);
            tests_run++;
            if (!seen || oh_idx(req_done) != e || xfer_err !== 1'b0)
                begin tests_failed++; $display("FAIL contention_done%0d seen=%0d done=%b err=%b exp idx %0d", k, seen, req_done, xfer_err, e); end
            if (k == 3) req_valid = '0;
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (start_cnt - s0 != 4 || overlap_cnt != 0 || ack_bad_cnt != 0)
            begin tests_failed++; $display("FAIL contention_starts got=%0d overlap=%0d ackbad=%0d exp 4/0/0", start_cnt - s0, overlap_cnt, ack_bad_cnt); end
    endtask

    task automatic test_master_busy();
        bit seen; int n, s0, e;
        m_mode = M_MANUAL;
        ready = 1'b0;
        s0 = start_cnt;
        set_req(1, 8'h55, 8'hAA);
        e = rr_model(2'b10, m_last);
        repeat (30) @(negedge clk);
        tests_run++;
        if (start_cnt != s0 || req_ack !== 2'b00 || busy !== 1'b0)
            begin tests_failed++; $display("FAIL busy_hold starts=%0d ack=%b busy=%b exp 0/00/0", start_cnt - s0, req_ack, busy); end
        ready = 1'b1;
        wait_start(20, seen, n);
        tests_run++;
        if (!seen || n != 2 || oh_idx(req_ack) != e)
            begin tests_failed++; $display("FAIL busy_release seen=%0d n=%0d ack=%b exp n=2 idx %0d", seen, n, req_ack, e); end
        req_valid[1] = 1'b0;
        m_last = e;
        repeat (3) @(negedge clk);
        ready = 1'b0;
        repeat (4) @(negedge clk);
        ready = 1'b1;
        wait_done(20, seen, n);
        tests_run++;
        if (!seen || n != 2 || xfer_err !== 1'b0)
            begin tests_failed++; $display("FAIL busy_done seen=%0d n=%0d err=%b exp n=2 err 0", seen, n, xfer_err); end
    endtask

    task automatic test_timeout(input int mode, input string tag);
        bit seen; int n, e;
        m_mode = mode; m_drop = 2;
        set_req(0, 8'h10, 8'h20);
        e = rr_model(2'b01, m_last);
        wait_start(20, seen, n);
        tests_run++;
        if (!seen || oh_idx(req_ack) != e) begin tests_failed++; $display("FAIL %s_start seen=%0d ack=%b exp idx %0d", tag, seen, req_ack, e); end
        req_valid[0] = 1'b0;
        m_last = e;
        wait_done(400, seen, n);
        tests_run++;
        if (!seen || n < TMO || n > TMO + 2)
            begin tests_failed++; $display("FAIL %s_lat seen=%0d n=%0d exp %0d..%0d", tag, seen, n, TMO, TMO + 2); end
        tests_run++;
        if (oh_idx(req_done) != e || xfer_err !== 1'b1 || timeout_flag !== 1'b1)
            begin tests_failed++; $display("FAIL %s_err done=%b err=%b flag=%b exp idx %0d/1/1", tag, req_done, xfer_err, timeout_flag, e); end
        @(negedge clk);
        tests_run++;
        if (xfer_err !== 1'b0 || timeout_flag !== 1'b1)
            begin tests_failed++; $display("FAIL %s_sticky err=%b flag=%b exp 0/1", tag, xfer_err, timeout_flag); end
        m_mode = M_MANUAL;
        ready = 1'b1;
        m_mode = M_NORMAL; m_drop = 1; m_low = 8;
        set_req(1, 8'h6B, 8'h3C);
        e = rr_model(2'b10, m_last);
        wait_start(20, seen, n);
        req_valid[1] = 1'b0;
        m_last = e;
        wait_done(100, seen, n);
        tests_run++;
        if (!seen || oh_idx(req_done) != e || xfer_err !== 1'b0 || timeout_flag !== 1'b1)
            begin tests_failed++; $display("FAIL %s_recover seen=%0d done=%b err=%b flag=%b exp idx %0d/0/1", tag, seen, req_done, xfer_err, timeout_flag, e); end
    endtask

    task automatic test_reset_mid();
        bit seen; int n, e;
        m_mode = M_NORMAL; m_drop = 2; m_low = 50;
        set_req(1, 8'h77, 8'h99);
        wait_start(20, seen, n);
        req_valid[1] = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || ready !== 1'b0) begin tests_failed++; $display("FAIL midreset_pre busy=%b ready=%b exp 1/0", busy, ready); end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({req_ack, req_done, xfer_err, timeout_flag, busy, sccb_start_sign, sccb_sub_address, sccb_set_data} !== '0)
            begin tests_failed++; $display("FAIL midreset_outputs flag=%b busy=%b addr=%h data=%h exp all 0",
                timeout_flag, busy, sccb_sub_address, sccb_set_data); end
        reset = 1'b0;
        m_last = NUM_REQ - 1;
        repeat (50) @(negedge clk);
        set_req(0, 8'h01, 8'h02);
        set_req(1, 8'h03, 8'h04);
        e = rr_model(2'b11, m_last);
        wait_start(20, seen, n);
        tests_run++;
        if (!seen || oh_idx(req_ack) != e || sccb_sub_address !== 8'h01)
            begin tests_failed++; $display("FAIL midreset_first seen=%0d ack=%b addr=%h exp idx %0d addr 01", seen, req_ack, sccb_sub_address, e); end
        req_valid = '0;
        m_last = e;
        wait_done(100, seen, n);
    endtask

    task automatic test_random();
        bit seen; int n, got, e;
        logic [NUM_REQ-1:0] pend;
        logic [7:0] ra[NUM_REQ], rd[NUM_REQ];
        pend = '0;
        req_valid = '0;
        m_mode = M_NORMAL;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    ra[i] = 8'($urandom_range(0, 255));
                    rd[i] = 8'($urandom_range(0, 255));
                    set_req(i, ra[i], rd[i]);
                end
            end
            if (pend == '0) begin
                e = $urandom_range(0, NUM_REQ - 1);
                pend[e] = 1'b1;
                ra[e] = 8'($urandom_range(0, 255));
                rd[e] = 8'($urandom_range(0, 255));
                set_req(e, ra[e], rd[e]);
            end
            m_drop = $urandom_range(0, 3);
            m_low = $urandom_range(1, 20);
            exp_q.push_back(W'(rr_model(pend, m_last)));
            wait_start(30, seen, n);
            got = oh_idx(req_ack);
            e = int'(exp_q.pop_front());
            tests_run++;
            if (!seen || got != e || sccb_sub_address !== ra[e] || sccb_set_data !== rd[e])
                begin tests_failed++; $display("FAIL rand_grant%0d seen=%0d got=%0d bus=%h/%h exp idx %0d bus=%h/%h",
                    r, seen, got, sccb_sub_address, sccb_set_data, e, ra[e], rd[e]); end
            req_valid[e] = 1'b0;
            pend[e] = 1'b0;
            m_last = e;
            wait_done(100, seen, n);
            tests_run++;
            if (!seen || n != m_drop + m_low + 2 || oh_idx(req_done) != e || xfer_err !== 1'b0)
                begin tests_failed++; $display("FAIL rand_done%0d seen=%0d n=%0d done=%b err=%b exp n=%0d idx %0d",
                    r, seen, n, req_done, xfer_err, m_drop + m_low + 2, e); end
        end
        req_valid = '0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (overlap_cnt != 0 || ack_bad_cnt != 0 || busy !== 1'b0)
            begin tests_failed++; $display("FAIL rand_protocol overlap=%0d ackbad=%0d busy=%b exp 0/0/0", overlap_cnt, ack_bad_cnt, busy); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_master_busy();
        test_timeout(M_NEVER, "timeout");
        test_timeout(M_STUCK, "stuck");
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout sim did not complete, got stuck at tests_run=%0d exp finish", tests_run);
        $fatal(1, "bench time limit");
    end

endmodule
